video_timing_gen: RTL and testbench

//  Parametrised raster timing generator; successor to the fixed 312x262 arcade counter chain.

---
 rtl/video_timing_gen.sv | 194 +++++++++++++++++++
 tb/tb_video_timing_gen.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/video_timing_gen.sv
// Parametrised raster timing generator: pixel-enable divider, h/v counters and
// registered blanking/sync/strobe decodes that stay coherent with h/v.
module video_timing_gen #(
    parameter int CE_DIV    = 4,
    parameter int H_TOTAL   = 312,
    parameter int HBL_START = 256,
    parameter int HBL_END   = 8,
    parameter int HS_START  = 264,
    parameter int HS_END    = 304,
    parameter int V_TOTAL   = 262,
    parameter int VBL_START = 224,
    parameter int VBL_END   = 32,
    parameter int VBLE_LEAD = 8,
    parameter int VS_START  = 256,
    parameter int VS_END    = 258,
    localparam int HW = $clog2(H_TOTAL),
    localparam int VW = $clog2(V_TOTAL)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [3:0]    hs_offset,
    input  logic [3:0]    vs_offset,
    output logic          ce_pix,
    output logic [HW-1:0] h,
    output logic [VW-1:0] v,
    output logic          hbl,
    output logic          vbl,
    output logic          vbl_early,
    output logic          hsync,
    output logic          vsync,
    output logic          line_start,
    output logic          frame_start
);

    localparam int PW = (HW > VW) ? HW : VW;
    localparam int CW = (CE_DIV > 1) ? $clog2(CE_DIV) : 1;

    localparam logic [CW-1:0] CNT_LAST = CW'(CE_DIV - 1);
    localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
    localparam logic [PW+1:0] H_TOT_W  = (PW+2)'(H_TOTAL);
    localparam logic [PW+1:0] V_TOT_W  = (PW+2)'(V_TOTAL);

    localparam logic [PW-1:0] HBL_A = PW'(HBL_START);
    localparam logic [PW-1:0] HBL_B = PW'(HBL_END);
    localparam logic [PW-1:0] VBL_A = PW'(VBL_START);
    localparam logic [PW-1:0] VBL_B = PW'(VBL_END);
    localparam logic [PW-1:0] VBE_A = PW'((VBL_START - VBLE_LEAD + V_TOTAL) % V_TOTAL);
    localparam logic [PW-1:0] VBE_B = PW'((VBL_END - VBLE_LEAD + V_TOTAL) % V_TOTAL);
    localparam logic [PW-1:0] HS_A0 = PW'(HS_START);
    localparam logic [PW-1:0] HS_B0 = PW'(HS_END);
    localparam logic [PW-1:0] VS_A0 = PW'(VS_START);
    localparam logic [PW-1:0] VS_B0 = PW'(VS_END);

    // Half-open region [a,b) on a circular axis; a > b means it wraps through 0.
    function automatic logic in_region(input logic [PW-1:0] x,
                                       input logic [PW-1:0] a,
                                       input logic [PW-1:0] b);
        logic r;
        if (a <= b) begin
            r = (x >= a) && (x < b);
        end else begin
            r = (x >= a) || (x < b);
        end
        return r;
    endfunction

    function automatic logic [PW-1:0] shift_mod(input logic [PW-1:0] base,
                                                input logic [3:0]    off,
                                                input logic [PW+1:0] total);
        logic signed [PW+1:0] sum;
        logic signed [PW+1:0] tot;
        logic signed [PW+1:0] wrapped;
        tot = $signed(total);
        sum = $signed({2'b00, base}) + $signed({{(PW-2){off[3]}}, off});
        if (sum[PW+1]) begin
            wrapped = sum + tot;
        end else if (sum >= tot) begin
            wrapped = sum - tot;
        end else begin
            wrapped = sum;
        end
        return wrapped[PW-1:0];
    endfunction

    function automatic logic [PW-1:0] widen_h(input logic [HW-1:0] x);
        logic [PW-1:0] w;
        w = '0;
        w[HW-1:0] = x;
        return w;
    endfunction

    function automatic logic [PW-1:0] widen_v(input logic [VW-1:0] x);
        logic [PW-1:0] w;
        w = '0;
        w[VW-1:0] = x;
        return w;
    endfunction

    logic [CW-1:0] cnt_r, cnt_nxt_s;
    logic          ce_pix_r, ce_nxt_s;
    logic [HW-1:0] h_r, h_nxt_s;
    logic [VW-1:0] v_r, v_nxt_s;
    logic [3:0]    hso_r, vso_r, hso_nxt_s, vso_nxt_s;
    logic          line_nxt_s, frame_nxt_s;
    logic [PW-1:0] hp_s, vp_s, hs_a_s, hs_b_s, vs_a_s, vs_b_s;
    logic          hbl_nxt_s, vbl_nxt_s, vble_nxt_s, hsync_nxt_s, vsync_nxt_s;
    logic          hbl_r, vbl_r, vble_r, hsync_r, vsync_r, ls_r, fs_r;

    // Next divider/counter state and the decodes of the position about to be presented.
    always_comb begin
        cnt_nxt_s   = (cnt_r == CNT_LAST) ? '0 : cnt_r + 1'b1;
        ce_nxt_s    = (cnt_nxt_s == CNT_LAST);
        h_nxt_s     = (h_r == H_LAST) ? '0 : h_r + 1'b1;
        if (h_r == H_LAST) begin
            v_nxt_s = (v_r == V_LAST) ? '0 : v_r + 1'b1;
        end else begin
            v_nxt_s = v_r;
        end
        line_nxt_s  = (h_nxt_s == '0);
        frame_nxt_s = line_nxt_s && (v_nxt_s == '0);
        // New offsets apply from the very first pixel of the frame.
        hso_nxt_s   = frame_nxt_s ? hs_offset : hso_r;
        vso_nxt_s   = frame_nxt_s ? vs_offset : vso_r;
        hp_s        = widen_h(h_nxt_s);
        vp_s        = widen_v(v_nxt_s);
        hs_a_s      = shift_mod(HS_A0, hso_nxt_s, H_TOT_W);
        hs_b_s      = shift_mod(HS_B0, hso_nxt_s, H_TOT_W);
        vs_a_s      = shift_mod(VS_A0, vso_nxt_s, V_TOT_W);
        vs_b_s      = shift_mod(VS_B0, vso_nxt_s, V_TOT_W);
        hbl_nxt_s   = in_region(hp_s, HBL_A, HBL_B);
        vbl_nxt_s   = in_region(vp_s, VBL_A, VBL_B);
        vble_nxt_s  = in_region(vp_s, VBE_A, VBE_B);
        hsync_nxt_s = in_region(hp_s, hs_a_s, hs_b_s);
        if (!hsync_r && hsync_nxt_s) begin
            if (vp_s == vs_a_s) begin
                vsync_nxt_s = 1'b1;
            end else if (vp_s == vs_b_s) begin
                vsync_nxt_s = 1'b0;
            end else begin
                vsync_nxt_s = vsync_r;
            end
        end else begin
            vsync_nxt_s = vsync_r;
        end
    end

    // State and output registers; everything but the divider moves only on pixel enables.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_r    <= '0;
            ce_pix_r <= 1'b0;
            h_r      <= '0;
            v_r      <= '0;
            hso_r    <= 4'd0;
            vso_r    <= 4'd0;
            hbl_r    <= in_region('0, HBL_A, HBL_B);
            vbl_r    <= in_region('0, VBL_A, VBL_B);
            vble_r   <= in_region('0, VBE_A, VBE_B);
            hsync_r  <= 1'b0;
            vsync_r  <= 1'b0;
            ls_r     <= 1'b1;
            fs_r     <= 1'b1;
        end else begin
            cnt_r    <= cnt_nxt_s;
            ce_pix_r <= ce_nxt_s;
            if (ce_nxt_s) begin
                h_r     <= h_nxt_s;
                v_r     <= v_nxt_s;
                hso_r   <= hso_nxt_s;
                vso_r   <= vso_nxt_s;
                hbl_r   <= hbl_nxt_s;
                vbl_r   <= vbl_nxt_s;
                vble_r  <= vble_nxt_s;
                hsync_r <= hsync_nxt_s;
                vsync_r <= vsync_nxt_s;
                ls_r    <= line_nxt_s;
                fs_r    <= frame_nxt_s;
            end
        end
    end

    assign ce_pix      = ce_pix_r;
    assign h           = h_r;
    assign v           = v_r;
    assign hbl         = hbl_r;
    assign vbl         = vbl_r;
    assign vbl_early   = vble_r;
    assign hsync       = hsync_r;
    assign vsync       = vsync_r;
    assign line_start  = ls_r;
    assign frame_start = fs_r;

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen: default geometry at CE_DIV=4 plus a small geometry at
// CE_DIV=1, both compared every clock against a pixel-index model, with table and event checks.
module tb_video_timing_gen;

    typedef struct {
        int ce_div; int ht; int hbs; int hbe; int hss; int hse;
        int vt; int vbs; int vbe; int lead; int vss; int vse;
    } geom_t;

    typedef struct {
        int k; int n; int hso; int vso; bit ce; bit hs; bit vs;
    } mstate_t;

    typedef struct {
        string name; int px; int h; int v; bit hbl; bit hs; bit ls; bit fs;
    } vec_t;

    typedef struct {
        int v; int h; bit vs;
    } ev_t;

    localparam logic [39:0] RST_A = {1'b0, 16'd0, 16'd0, 7'b1110011};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_a, rst_b;
    logic [3:0] hoa, voa, hob, vob;
    logic       ce_a, hbl_a, vbl_a, vble_a, hs_a, vs_a, ls_a, fs_a;
    logic [8:0] h_a, v_a;
    logic       ce_b, hbl_b, vbl_b, vble_b, hs_b, vs_b, ls_b, fs_b;
    logic [5:0] h_b;
    logic [4:0] v_b;

    video_timing_gen dut_a (
        .clk(clk), .reset(rst_a), .hs_offset(hoa), .vs_offset(voa),
        .ce_pix(ce_a), .h(h_a), .v(v_a), .hbl(hbl_a), .vbl(vbl_a), .vbl_early(vble_a),
        .hsync(hs_a), .vsync(vs_a), .line_start(ls_a), .frame_start(fs_a)
    );

    video_timing_gen #(
        .CE_DIV(1), .H_TOTAL(40), .HBL_START(32), .HBL_END(4), .HS_START(34), .HS_END(38),
        .V_TOTAL(30), .VBL_START(24), .VBL_END(3), .VBLE_LEAD(4), .VS_START(26), .VS_END(28)
    ) dut_b (
        .clk(clk), .reset(rst_b), .hs_offset(hob), .vs_offset(vob),
        .ce_pix(ce_b), .h(h_b), .v(v_b), .hbl(hbl_b), .vbl(vbl_b), .vbl_early(vble_b),
        .hsync(hs_b), .vsync(vs_b), .line_start(ls_b), .frame_start(fs_b)
    );

    logic [39:0] act_a, act_b;
    assign act_a = {ce_a, 16'(h_a), 16'(v_a), hbl_a, vbl_a, vble_a, hs_a, vs_a, ls_a, fs_a};
    assign act_b = {ce_b, 16'(h_b), 16'(v_b), hbl_b, vbl_b, vble_b, hs_b, vs_b, ls_b, fs_b};

    geom_t   ga, gb;
    mstate_t sa, sb;
    vec_t    line_tbl[12];
    ev_t     ev_q[$];
    int      fs_q[$];
    int      n_checks = 0;
    int      n_pass = 0;
    int      clk_no = 0;
    logic    prev_vs_b = 1'b0;
    logic    prev_fs_b = 1'b1;

    function automatic int md(input int x, input int t);
        return ((x % t) + t) % t;
    endfunction

    function automatic bit inreg(input int x, input int a, input int b);
        return (a <= b) ? (x >= a && x < b) : (x >= a || x < b);
    endfunction

    function automatic int sext4(input logic [3:0] x);
        return x[3] ? int'({28'd0, x}) - 16 : int'({28'd0, x});
    endfunction

    // Model: pixel index n since reset; position and regions follow by plain arithmetic.
    function automatic mstate_t mstep(input geom_t g, input mstate_t s, input bit rst,
                                      input logic [3:0] hin, input logic [3:0] vin);
        mstate_t r;
        int hh, vv;
        bit hsn;
        r = s;
        if (rst) begin
            r.k = 0; r.n = 0; r.hso = 0; r.vso = 0; r.ce = 1'b0; r.hs = 1'b0; r.vs = 1'b0;
        end else begin
            r.k  = s.k + 1;
            r.ce = ((r.k % g.ce_div) == g.ce_div - 1);
            if (r.ce) begin
                r.n = s.n + 1;
                hh  = r.n % g.ht;
                vv  = (r.n / g.ht) % g.vt;
                if (hh == 0 && vv == 0) begin
                    r.hso = sext4(hin);
                    r.vso = sext4(vin);
                end
                hsn = inreg(hh, md(g.hss + r.hso, g.ht), md(g.hse + r.hso, g.ht));
                if (!s.hs && hsn) begin
                    if (vv == md(g.vss + r.vso, g.vt)) r.vs = 1'b1;
                    else if (vv == md(g.vse + r.vso, g.vt)) r.vs = 1'b0;
                end
                r.hs = hsn;
            end
        end
        return r;
    endfunction

    function automatic logic [39:0] mexp(input geom_t g, input mstate_t s);
        int hh, vv;
        hh = s.n % g.ht;
        vv = (s.n / g.ht) % g.vt;
        return {s.ce, 16'(hh), 16'(vv), inreg(hh, g.hbs, g.hbe), inreg(vv, g.vbs, g.vbe),
                inreg(vv, md(g.vbs - g.lead, g.vt), md(g.vbe - g.lead, g.vt)),
                s.hs, s.vs, hh == 0, (hh == 0) && (vv == 0)};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (clk %0d)", name, act, exp, clk_no);
    endtask

    task automatic tick();
        @(posedge clk);
        sa = mstep(ga, sa, rst_a, hoa, voa);
        sb = mstep(gb, sb, rst_b, hob, vob);
        clk_no++;
        @(negedge clk);
        check("model_a", 64'(act_a), 64'(mexp(ga, sa)));
        check("model_b", 64'(act_b), 64'(mexp(gb, sb)));
        if (vs_b !== prev_vs_b) ev_q.push_back('{int'(v_b), int'(h_b), vs_b});
        prev_vs_b = vs_b;
        if (fs_b && !prev_fs_b) fs_q.push_back(clk_no);
        prev_fs_b = fs_b;
    endtask

    task automatic run_line_table(input string tag);
        int guard;
        for (int i = 0; i < 12; i++) begin
            guard = 0;
            while (sa.n < line_tbl[i].px && guard < 3000) begin
                tick();
                guard++;
            end
            check({tag, "_", line_tbl[i].name},
                  64'({16'(h_a), 16'(v_a), hbl_a, hs_a, vs_a, ls_a, fs_a}),
                  64'({16'(line_tbl[i].h), 16'(line_tbl[i].v), line_tbl[i].hbl,
                       line_tbl[i].hs, 1'b0, line_tbl[i].ls, line_tbl[i].fs}));
        end
    endtask

    initial begin
        int guard;
        int r0;
        ev_t exp_ev[4];

        ga = '{4, 312, 256, 8, 264, 304, 262, 224, 32, 8, 256, 258};
        gb = '{1, 40, 32, 4, 34, 38, 30, 24, 3, 4, 26, 28};
        sa = '{0, 0, 0, 0, 1'b0, 1'b0, 1'b0};
        sb = '{0, 0, 0, 0, 1'b0, 1'b0, 1'b0};
        line_tbl[0]  = '{"px2",      2,   2,   0, 1'b1, 1'b0, 1'b0, 1'b0};
        line_tbl[1]  = '{"hbl_last", 7,   7,   0, 1'b1, 1'b0, 1'b0, 1'b0};
        line_tbl[2]  = '{"hbl_fall", 8,   8,   0, 1'b0, 1'b0, 1'b0, 1'b0};
        line_tbl[3]  = '{"vis_last", 255, 255, 0, 1'b0, 1'b0, 1'b0, 1'b0};
        line_tbl[4]  = '{"hbl_rise", 256, 256, 0, 1'b1, 1'b0, 1'b0, 1'b0};
        line_tbl[5]  = '{"hs_pre",   263, 263, 0, 1'b1, 1'b0, 1'b0, 1'b0};
        line_tbl[6]  = '{"hs_rise",  264, 264, 0, 1'b1, 1'b1, 1'b0, 1'b0};
        line_tbl[7]  = '{"hs_last",  303, 303, 0, 1'b1, 1'b1, 1'b0, 1'b0};
        line_tbl[8]  = '{"hs_fall",  304, 304, 0, 1'b1, 1'b0, 1'b0, 1'b0};
        line_tbl[9]  = '{"h_max",    311, 311, 0, 1'b1, 1'b0, 1'b0, 1'b0};
        line_tbl[10] = '{"h_wrap",   312, 0,   1, 1'b1, 1'b0, 1'b1, 1'b0};
        line_tbl[11] = '{"ls_fall",  313, 1,   1, 1'b1, 1'b0, 1'b0, 1'b0};
        exp_ev[0] = '{26, 34, 1'b1};
        exp_ev[1] = '{28, 34, 1'b0};
        exp_ev[2] = '{29, 26, 1'b1};
        exp_ev[3] = '{1,  26, 1'b0};

        rst_a = 1'b1; rst_b = 1'b1;
        hoa = 4'd0; voa = 4'd0; hob = 4'd0; vob = 4'd0;
        tick();
        tick();
        check("reset_a", 64'(act_a), 64'(RST_A));
        rst_a = 1'b0;

        // Divider cadence and first pixel after reset.
        for (int i = 0; i < 8; i++) begin
            tick();
            check("ce_div4", 64'(ce_a), 64'((i % 4) == 2));
            if (i == 2) check("first_h", 64'(h_a), 64'd1);
        end
        run_line_table("line");

        // Mid-line reset, then the same line must replay.
        guard = 0;
        while (sa.n < 512 && guard < 3000) begin
            tick();
            guard++;
        end
        rst_a = 1'b1;
        tick();
        rst_a = 1'b0;
        check("reset_mid", 64'(act_a), 64'(RST_A));
        run_line_table("replay");

        // Small geometry: offsets changed mid-frame take effect only next frame.
        rst_b = 1'b0;
        r0 = clk_no;
        for (int i = 0; i < 400; i++) tick();
        hob = 4'b1000;
        vob = 4'd3;
        guard = 0;
        while ((ev_q.size() < 4 || fs_q.size() < 2) && guard < 5000) begin
            tick();
            guard++;
        end
        check("vs_event_count", 64'(ev_q.size() >= 4), 64'd1);
        for (int i = 0; i < 4; i++) begin
            if (i < ev_q.size())
                check($sformatf("vs_event%0d", i),
                      64'({16'(ev_q[i].v), 16'(ev_q[i].h), ev_q[i].vs}),
                      64'({16'(exp_ev[i].v), 16'(exp_ev[i].h), exp_ev[i].vs}));
        end
        check("fs_count", 64'(fs_q.size() >= 2), 64'd1);
        if (fs_q.size() >= 2) begin
            check("first_frame_len", 64'(fs_q[0] - r0), 64'd1200);
            check("frame_len", 64'(fs_q[1] - fs_q[0]), 64'd1200);
        end

        // Random offsets and occasional resets, checked against the model every clock.
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 99) == 0) begin
                hob = 4'($urandom_range(0, 15));
                vob = 4'($urandom_range(0, 15));
                hoa = 4'($urandom_range(0, 15));
                voa = 4'($urandom_range(0, 15));
            end
            rst_b = ($urandom_range(0, 1999) == 0);
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
